// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one spi_master.
// Only one transfer is in flight at a time. The grant is held from arbitration
// until the one-cycle ack. Every output comes straight from a flop.
module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      spi_start,
  output logic [DATA_W-1:0]         spi_data_in,
  input  logic [DATA_W-1:0]         spi_data_out,
  input  logic                      spi_done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;
  logic                 spi_start_q, spi_start_d;
  logic [DATA_W-1:0]    spi_data_in_q, spi_data_in_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Per-requester TX words and the round-robin search order.
  logic [DATA_W-1:0]    req_word [NUM_REQ];
  logic [PTR_W-1:0]     cand_idx [NUM_REQ];
  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;

  // cand_idx[gi] is the requester checked gi places after rr_ptr, with wrap.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
    assign cand_idx[gi] = PTR_W'((int'(rr_ptr_q) + gi) % NUM_REQ);
  end

  // Scan from the farthest candidate toward rr_ptr. The nearest set request is written last, so it wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ack_d         = '0;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    spi_start_d   = 1'b0;
    spi_data_in_d = spi_data_in_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = START;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          spi_data_in_d    = req_word[win_idx];
          spi_start_d      = 1'b1;
          rr_ptr_d         = PTR_W'((int'(win_idx) + 1) % NUM_REQ);
        end
      end
      START: begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
      end
      WAIT_DONE: begin
        // At cnt == 0 the done input may still be high from the previous transfer, so it is ignored.
        if (spi_done && (cnt_q != '0)) begin
          state_d    = RESP;
          rsp_data_d = spi_data_out;
          rsp_err_d  = 1'b0;
          ack_d      = gnt_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = RESP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          ack_d      = gnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers. Reset asynchronously drops any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      ack_q         <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      spi_start_q   <= 1'b0;
      spi_data_in_q <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      ack_q         <= ack_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
      spi_start_q   <= spi_start_d;
      spi_data_in_q <= spi_data_in_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign spi_start   = spi_start_q;
  assign spi_data_in = spi_data_in_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter. The bench drives and samples on the falling edge.
module tb_spi_master_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        spi_start;
  logic [7:0]  spi_data_in;
  logic [7:0]  spi_data_out;
  logic        spi_done;

  int n_checks = 0;
  int n_fail   = 0;

  spi_master_arbiter #(
    .NUM_REQ(4),
    .DATA_W(8),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .ack(ack),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .busy(busy),
    .spi_start(spi_start),
    .spi_data_in(spi_data_in),
    .spi_data_out(spi_data_out),
    .spi_done(spi_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All outputs are zero while reset is held.
  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0)      begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_checks++; if (ack !== 4'b0)      begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", spi_start); end
    n_checks++; if (rsp_err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %b expected 0", rsp_err); end
    n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 00", rsp_data); end
    n_checks++; if (spi_data_in !== 8'h00) begin n_fail++; $display("FAIL reset_spi_data_in: got %h expected 00", spi_data_in); end
    rst_n = 1'b1;
    $display("test_reset: done");
  endtask

  // A single transfer for requester 2, with done arriving 20 cycles after the start.
  task automatic test_single();
    int starts, gnt_bad, ack_at;
    req_data = 32'h44CC_2211;
    req      = 4'b0100;
    @(negedge clk);                    // cycle 1: START
    n_checks++; if (gnt !== 4'b0100)   begin n_fail++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
    n_checks++; if (spi_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", spi_start); end
    n_checks++; if (spi_data_in !== 8'hCC) begin n_fail++; $display("FAIL single_txword: got %h expected cc", spi_data_in); end
    n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    starts = 1; gnt_bad = 0; ack_at = -1;
    for (int c = 2; c <= 60 && ack_at < 0; c++) begin
      @(negedge clk);
      if (spi_start) starts++;
      if (gnt !== 4'b0100) gnt_bad++;
      if (ack !== 4'b0) ack_at = c;
      if (c == 5) req_data = 32'h4455_2211;   // a later change must not reach spi_data_in
      if (c == 21) begin spi_done = 1'b1; spi_data_out = 8'hAD; end
    end
    n_checks++; if (ack_at !== 22)     begin n_fail++; $display("FAIL single_ack_cycle: got %0d expected 22", ack_at); end
    n_checks++; if (ack !== 4'b0100)   begin n_fail++; $display("FAIL single_ack: got %b expected 0100", ack); end
    n_checks++; if (rsp_data !== 8'hAD) begin n_fail++; $display("FAIL single_rsp_data: got %h expected ad", rsp_data); end
    n_checks++; if (rsp_err !== 1'b0)  begin n_fail++; $display("FAIL single_rsp_err: got %b expected 0", rsp_err); end
    n_checks++; if (spi_data_in !== 8'hCC) begin n_fail++; $display("FAIL single_txword_stable: got %h expected cc", spi_data_in); end
    n_checks++; if (starts !== 1)      begin n_fail++; $display("FAIL single_start_count: got %0d expected 1", starts); end
    n_checks++; if (gnt_bad !== 0)     begin n_fail++; $display("FAIL single_gnt_held: got %0d bad cycles expected 0", gnt_bad); end
    spi_done = 1'b0;
    req      = 4'b0;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0 || ack !== 4'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL single_idle: got gnt=%b ack=%b busy=%b expected 0000 0000 0", gnt, ack, busy); end
    n_checks++; if (rsp_data !== 8'hAD) begin n_fail++; $display("FAIL single_rsp_hold: got %h expected ad", rsp_data); end
    $display("test_single: ack at cycle %0d rsp_data=%h", ack_at, rsp_data);
  endtask

  // After a reset, all four requesters hold req. Grants must follow 0,1,2,3,0.
  task automatic test_back_to_back();
    logic [3:0] order [5];
    logic [3:0] exp_order [5];
    logic [7:0] exp_rd;
    int start_c, n_gnt, n_ack, multi;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    for (int i = 0; i < 5; i++) order[i] = 4'b0;
    rst_n = 1'b0;
    @(negedge clk);
    req_data = 32'hD3C2_B1A0;
    req      = 4'b1111;
    rst_n    = 1'b1;
    start_c = -100; n_gnt = 0; n_ack = 0; multi = 0;
    for (int c = 1; c <= 200 && n_ack < 5; c++) begin
      @(negedge clk);
      if ($countones(gnt) > 1 || $countones(ack) > 1) multi++;
      if (spi_start) begin
        if (n_gnt < 5) order[n_gnt] = gnt;
        n_gnt++;
        start_c = c;
      end
      if (ack !== 4'b0) begin
        exp_rd = 8'h30 + 8'(n_ack);
        n_checks++; if (rsp_data !== exp_rd)
          begin n_fail++; $display("FAIL b2b_rsp_data: got %h expected %h", rsp_data, exp_rd); end
        n_ack++;
        spi_done = 1'b0;
        if (n_ack == 5) req = 4'b0;
      end
      if (c == start_c + 5) begin
        spi_done     = 1'b1;
        spi_data_out = 8'h30 + 8'(n_gnt - 1);
      end
    end
    n_checks++; if (n_ack !== 5) begin n_fail++; $display("FAIL b2b_ack_count: got %0d expected 5", n_ack); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (order[i] !== exp_order[i])
        begin n_fail++; $display("FAIL b2b_order[%0d]: got %b expected %b", i, order[i], exp_order[i]); end
    end
    n_checks++; if (multi !== 0) begin n_fail++; $display("FAIL b2b_onehot: got %0d multi-hot cycles expected 0", multi); end
    @(negedge clk);
    $display("test_back_to_back: %0d grants, order %b %b %b %b %b", n_gnt, order[0], order[1], order[2], order[3], order[4]);
  endtask

  // With no done, the ack comes TIMEOUT_CYCLES cycles after WAIT_DONE is entered.
  task automatic test_timeout();
    int ack_at;
    req_data = 32'h0000_00E7;
    req      = 4'b0001;
    @(negedge clk);                    // cycle 1: START; WAIT_DONE starts at cycle 2
    ack_at = -1;
    for (int c = 2; c <= 1200 && ack_at < 0; c++) begin
      @(negedge clk);
      if (ack !== 4'b0) ack_at = c;
    end
    n_checks++; if (ack_at !== 1026) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected 1026", ack_at); end
    n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL timeout_ack: got %b expected 0001", ack); end
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", rsp_err); end
    n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL timeout_data: got %h expected 00", rsp_data); end
    req = 4'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || gnt !== 4'b0)
      begin n_fail++; $display("FAIL timeout_idle: got busy=%b gnt=%b expected 0 0000", busy, gnt); end
    $display("test_timeout: ack at cycle %0d err=%b", ack_at, rsp_err);
  endtask

  // Reset during WAIT_DONE clears every output at once. The first grant afterwards goes to the lowest set index.
  task automatic test_reset_midflight();
    int ack_seen, ack_at;
    req_data = 32'h005A_3300;
    req      = 4'b0100;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL midrst_pre_gnt: got %b expected 0100", gnt); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0 || ack !== 4'b0 || busy !== 1'b0 || spi_start !== 1'b0)
      begin n_fail++; $display("FAIL midrst_ctrl: got gnt=%b ack=%b busy=%b start=%b expected all zero", gnt, ack, busy, spi_start); end
    n_checks++; if (rsp_err !== 1'b0 || rsp_data !== 8'h00 || spi_data_in !== 8'h00)
      begin n_fail++; $display("FAIL midrst_data: got err=%b rsp=%h txw=%h expected 0 00 00", rsp_err, rsp_data, spi_data_in); end
    ack_seen = 0;
    @(negedge clk);
    if (ack !== 4'b0) ack_seen++;
    req   = 4'b0110;
    rst_n = 1'b1;
    @(negedge clk);
    if (ack !== 4'b0) ack_seen++;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL midrst_first_gnt: got %b expected 0010", gnt); end
    n_checks++; if (ack_seen !== 0) begin n_fail++; $display("FAIL midrst_no_ack: got %0d acks expected 0", ack_seen); end
    // Finish requester 1's transfer so the stale-done test starts from IDLE.
    ack_at = -1;
    for (int c = 2; c <= 40 && ack_at < 0; c++) begin
      @(negedge clk);
      if (ack !== 4'b0) ack_at = c;
      if (c == 4) begin spi_done = 1'b1; spi_data_out = 8'h61; end
    end
    n_checks++; if (ack !== 4'b0010 || rsp_data !== 8'h61)
      begin n_fail++; $display("FAIL midrst_finish: got ack=%b rsp=%h expected 0010 61", ack, rsp_data); end
    spi_done = 1'b0;
    req      = 4'b0;
    @(negedge clk);
    $display("test_reset_midflight: first grant after reset to requester 1, ack at cycle %0d", ack_at);
  endtask

  // A done level left high from before must be ignored until the real pulse. Dropping req mid-transfer does not cancel the ack.
  task automatic test_stale_done();
    int ack_at;
    req_data     = 32'h0000_7700;
    spi_data_out = 8'h99;
    spi_done     = 1'b1;               // high while IDLE
    req          = 4'b0010;
    @(negedge clk);                    // cycle 1: START
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL stale_gnt: got %b expected 0010", gnt); end
    ack_at = -1;
    for (int c = 2; c <= 40 && ack_at < 0; c++) begin
      @(negedge clk);
      if (ack !== 4'b0) ack_at = c;
      if (c == 3) spi_done = 1'b0;     // high through the first WAIT_DONE cycle
      if (c == 4) req = 4'b0000;
      if (c == 12) begin spi_done = 1'b1; spi_data_out = 8'h55; end
      if (c == 13) spi_done = 1'b0;
    end
    n_checks++; if (ack_at !== 13)   begin n_fail++; $display("FAIL stale_ack_cycle: got %0d expected 13", ack_at); end
    n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL stale_ack: got %b expected 0010", ack); end
    n_checks++; if (rsp_data !== 8'h55 || rsp_err !== 1'b0)
      begin n_fail++; $display("FAIL stale_rsp: got %h err=%b expected 55 0", rsp_data, rsp_err); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || ack !== 4'b0)
      begin n_fail++; $display("FAIL stale_idle: got busy=%b ack=%b expected 0 0000", busy, ack); end
    $display("test_stale_done: ack at cycle %0d rsp_data=%h", ack_at, rsp_data);
  endtask

  initial begin
    rst_n        = 1'b0;
    req          = 4'b0;
    req_data     = 32'h0;
    spi_data_out = 8'h00;
    spi_done     = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_reset_midflight();
    test_stale_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
